// File: rtl/wb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// wb_bram_arbiter
// Two-master Wishbone arbiter for an 8x32 BRAM slave: round-robin on ties,
// no preemption, zero-gap handover. Define WB_ARB_TIMEOUT_EN to add a
// stalled-strobe watchdog with per-master Mn_ERR_O outputs.
// Revision: 1.0
// ============================================================================
module wb_bram_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [2:0]  M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  output logic [31:0] M0_DAT_O,
  output logic        M0_ACK_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [2:0]  M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  output logic [31:0] M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [2:0]  S_ADR_O,
  output logic [31:0] S_DAT_O,
  input  logic [31:0] S_DAT_I,
  input  logic        S_ACK_I,
`ifdef WB_ARB_TIMEOUT_EN
  output logic        M0_ERR_O,
  output logic        M1_ERR_O,
`endif
  output logic [1:0]  GNT_O
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       tmo_abort;

`ifdef WB_ARB_TIMEOUT_EN
  logic [3:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_abort = (state_q != ST_IDLE) && (tmo_cnt_q == 4'(TIMEOUT));

  // Counts only stalled strobes of the current owner; any ACK or ownership
  // change restarts the window.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == ST_IDLE) || (state_d != state_q) || S_ACK_I) begin
      tmo_cnt_d = 4'd0;
    end else if (S_STB_O) begin
      tmo_cnt_d = tmo_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tmo_cnt_q <= 4'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign M0_ERR_O = tmo_abort && (state_q == ST_OWN0);
  assign M1_ERR_O = tmo_abort && (state_q == ST_OWN1);
`else
  logic [3:0] unused_timeout;

  assign tmo_abort      = 1'b0;
  assign unused_timeout = 4'(TIMEOUT);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (M0_CYC_I && M1_CYC_I) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (M0_CYC_I) begin
          state_d = ST_OWN0;
        end else if (M1_CYC_I) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!M0_CYC_I) begin
          state_d = M1_CYC_I ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!M1_CYC_I) begin
          state_d = M0_CYC_I ? ST_OWN0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_abort) begin
      state_d = ST_IDLE;
    end

    if ((state_d == ST_OWN0) && (state_q != ST_OWN0)) begin
      last_d = 1'b0;
    end else if ((state_d == ST_OWN1) && (state_q != ST_OWN1)) begin
      last_d = 1'b1;
    end

    // An aborted owner is recorded as most recent so the other master wins a tie.
    if (tmo_abort) begin
      last_d = (state_q == ST_OWN1);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    S_STB_O = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = 3'd0;
    S_DAT_O = 32'd0;
    case (state_q)
      ST_OWN0: begin
        S_STB_O = M0_STB_I & M0_CYC_I;
        S_WE_O  = M0_WE_I;
        S_ADR_O = M0_ADR_I;
        S_DAT_O = M0_DAT_I;
      end
      ST_OWN1: begin
        S_STB_O = M1_STB_I & M1_CYC_I;
        S_WE_O  = M1_WE_I;
        S_ADR_O = M1_ADR_I;
        S_DAT_O = M1_DAT_I;
      end
      default: ;
    endcase
  end

  assign M0_ACK_O = S_ACK_I & (state_q == ST_OWN0) & M0_STB_I;
  assign M1_ACK_O = S_ACK_I & (state_q == ST_OWN1) & M1_STB_I;
  assign M0_DAT_O = S_DAT_I;
  assign M1_DAT_O = S_DAT_I;
  assign GNT_O    = {state_q == ST_OWN1, state_q == ST_OWN0};

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_bram_arbiter
// BRAM slave model, per-master scoreboards, directed and random traffic.
// Revision: 1.0
// ============================================================================
module tb_wb_bram_arbiter;
  localparam int BUDGET = 64;
  localparam int TMO    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  m_cyc, m_stb, m_we;
  logic [2:0]  m_adr [2];
  logic [31:0] m_dat [2];
  logic        ack0, ack1;
  logic [31:0] dat_o0, dat_o1;
  logic        s_stb, s_we, s_ack;
  logic [2:0]  s_adr;
  logic [31:0] s_dat_o, s_dat_i;
  logic [1:0]  gnt;
  logic [1:0]  m_ack;
`ifdef WB_ARB_TIMEOUT_EN
  logic        err0, err1;
`endif
  assign m_ack = {ack1, ack0};

  wb_bram_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(m_cyc[0]), .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]),
    .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_dat[0]), .M0_DAT_O(dat_o0), .M0_ACK_O(ack0),
    .M1_CYC_I(m_cyc[1]), .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]),
    .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_dat[1]), .M1_DAT_O(dat_o1), .M1_ACK_O(ack1),
    .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr), .S_DAT_O(s_dat_o),
    .S_DAT_I(s_dat_i), .S_ACK_I(s_ack),
`ifdef WB_ARB_TIMEOUT_EN
    .M0_ERR_O(err0), .M1_ERR_O(err1),
`endif
    .GNT_O(gnt)
  );

  // 8x32 BRAM: writes acknowledged at once, reads one cycle after the strobe.
  logic [31:0] slv_mem [8];
  logic        rd_pend;
  logic        stall = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= s_stb & ~s_we & ~rd_pend & ~stall;
      if (s_stb & s_we & ~stall) slv_mem[s_adr] <= s_dat_o;
      s_dat_i <= slv_mem[s_adr];
    end
  end
  assign s_ack = ~stall & ((s_stb & s_we) | (s_stb & rd_pend));

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] model_mem [8];
  int          gnt_log[$];
  logic [1:0]  gnt_prev = 2'b00;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score(input int n);
    exp_t        e;
    logic [31:0] rd;
    bit          have;
    have = 1'b0;
    if (n == 0 && q0.size() > 0) begin e = q0.pop_front(); rd = dat_o0; have = 1'b1; end
    if (n == 1 && q1.size() > 0) begin e = q1.pop_front(); rd = dat_o1; have = 1'b1; end
    if (!have) begin
      n_chk++; n_fail++;
      $display("FAIL m%0d_unexpected_ack: got ack expected none at %0t", n, $time);
    end else begin
      check($sformatf("m%0d_we", n), 32'(s_we), 32'(e.we));
      check($sformatf("m%0d_adr", n), 32'(s_adr), 32'(e.adr));
      if (e.we) check($sformatf("m%0d_wdata", n), s_dat_o, e.dat);
      else      check($sformatf("m%0d_rdata", n), rd, e.dat);
    end
  endtask

  // Monitor: pops the scoreboards on ACK and checks bus invariants every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt !== gnt_prev) begin
          gnt_log.push_back(int'(gnt));
          gnt_prev = gnt;
        end
        if (ack0) score(0);
        if (ack1) score(1);
        check("gnt_onehot", 32'(gnt == 2'b11), 32'd0);
        check("ack_non_owner", 32'(m_ack & ~gnt), 32'd0);
        if (gnt == 2'b00)
          check("idle_bus_zero", 32'({s_stb, s_we, s_adr} | 5'(|s_dat_o)), 32'd0);
        for (int n = 0; n < 2; n++) begin
          if (gnt[n]) begin
            check($sformatf("s_adr_tracks_m%0d", n), 32'(s_adr), 32'(m_adr[n]));
            check($sformatf("s_stb_tracks_m%0d", n), 32'(s_stb), 32'(m_stb[n] & m_cyc[n]));
          end
        end
      end
    end
  end

  task automatic xfer(input int n, input bit we, input logic [2:0] adr,
                      input logic [31:0] dat, output int lat);
    exp_t e;
    bit   done;
    e.we  = we;
    e.adr = adr;
    e.dat = we ? dat : model_mem[adr];
    if (we) model_mem[adr] = dat;
    if (n == 0) q0.push_back(e); else q1.push_back(e);
    m_stb[n] = 1'b1; m_we[n] = we; m_adr[n] = adr; m_dat[n] = dat;
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      @(negedge clk);
      if (m_ack[n]) done = 1'b1; else lat++;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL m%0d_ack_timeout: got no ack expected ack within %0d cycles", n, BUDGET);
    end
    @(posedge clk); #1;
    m_stb[n] = 1'b0;
    m_we[n]  = 1'($urandom);
    m_adr[n] = 3'($urandom);
    m_dat[n] = $urandom;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_stb"}, 32'(s_stb), 32'd0);
    check({tag, "_s_we"}, 32'(s_we), 32'd0);
    check({tag, "_s_adr"}, 32'(s_adr), 32'd0);
    check({tag, "_s_dat"}, s_dat_o, 32'd0);
    check({tag, "_acks"}, 32'(m_ack), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
`ifdef WB_ARB_TIMEOUT_EN
    check({tag, "_err"}, 32'({err1, err0}), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = 2'b00; m_stb = 2'b00;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    gnt_prev = 2'b00;
    rst = 1'b0;
  endtask

  int          lat;
  logic [31:0] old7;
  int          exp_log[$];
  int          stb_cnt;
  bit          got;

  initial begin
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    m_adr[0] = 3'd0; m_adr[1] = 3'd0; m_dat[0] = 32'd0; m_dat[1] = 32'd0;
    do_reset();

    // Fill the whole BRAM so every later read has a known value.
    m_cyc[0] = 1'b1;
    for (int i = 0; i < 8; i++) xfer(0, 1'b1, 3'(i), $urandom, lat);
    m_cyc[0] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Write then read ADR 3 from M0.
    m_cyc[0] = 1'b1;
    xfer(0, 1'b1, 3'd3, 32'hDEADBEEF, lat);
    check("wr_ack_latency_from_idle", 32'(lat), 32'd1);
    check("gnt_m0_owner", 32'(gnt), 32'd1);
    xfer(0, 1'b0, 3'd3, 32'd0, lat);
    check("rd_ack_latency", 32'(lat), 32'd1);
    m_cyc[0] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // M1 strobes while M0 owns: M1 must wait and never reach the slave early.
    old7 = model_mem[7];
    fork
      begin
        m_cyc[0] = 1'b1;
        for (int k = 0; k < 3; k++) xfer(0, 1'b1, 3'(k), $urandom, lat);
        check("m1_no_early_write", slv_mem[7], old7);
        m_cyc[0] = 1'b0;
      end
      begin
        @(posedge clk); #1;
        m_cyc[1] = 1'b1;
        xfer(1, 1'b1, 3'd7, $urandom, lat);
        m_cyc[1] = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset in the middle of an M1 read.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 3'd5;
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      if (gnt == 2'b10 && s_stb) got = 1'b1;
    end
    check("m1_read_started", 32'(got), 32'd1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    do_reset();

    // Tie straight after reset: M0 first, then M1 with no idle gap.
    gnt_log.delete();
    fork
      begin m_cyc[0] = 1'b1; xfer(0, 1'b1, 3'd1, $urandom, lat); m_cyc[0] = 1'b0; end
      begin m_cyc[1] = 1'b1; xfer(1, 1'b1, 3'd6, $urandom, lat); m_cyc[1] = 1'b0; end
    join
    repeat (2) @(posedge clk); #1;
    exp_log = '{1, 2, 0};
    check("tie_log_len", 32'(gnt_log.size()), 32'(exp_log.size()));
    if (gnt_log.size() == exp_log.size())
      for (int i = 0; i < exp_log.size(); i++)
        check($sformatf("tie_gnt_%0d", i), 32'(gnt_log[i]), 32'(exp_log[i]));

    // Both request continuously, one transfer per tenure: grants alternate.
    do_reset();
    gnt_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          m_cyc[0] = 1'b1; xfer(0, 1'b1, 3'(k), $urandom, lat); m_cyc[0] = 1'b0;
          @(posedge clk); #1;
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          m_cyc[1] = 1'b1; xfer(1, 1'b1, 3'(4 + k), $urandom, lat); m_cyc[1] = 1'b0;
          @(posedge clk); #1;
        end
      end
    join
    repeat (2) @(posedge clk); #1;
    exp_log.delete();
    for (int i = 0; i < 6; i++) exp_log.push_back((i % 2 == 0) ? 1 : 2);
    exp_log.push_back(0);
    check("rr_log_len", 32'(gnt_log.size()), 32'(exp_log.size()));
    if (gnt_log.size() == exp_log.size())
      for (int i = 0; i < exp_log.size(); i++)
        check($sformatf("rr_gnt_%0d", i), 32'(gnt_log[i]), 32'(exp_log[i]));

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: M0 aborted after TIMEOUT strobe cycles, M1 then granted.
    stall = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 3'd0;
    @(posedge clk); #1;
    m_cyc[1] = 1'b1;
    stb_cnt = 0; got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      if (err0) got = 1'b1;
      else if (s_stb) stb_cnt++;
    end
    check("err0_seen", 32'(got), 32'd1);
    check("err0_after_stb_cycles", 32'(stb_cnt), 32'(TMO));
    @(negedge clk);
    check("err0_single_pulse", 32'(err0), 32'd0);
    check("idle_after_abort", 32'(gnt), 32'd0);
    @(negedge clk);
    check("m1_after_abort", 32'(gnt), 32'd2);
    @(posedge clk); #1;
    m_cyc = 2'b00; m_stb = 2'b00; stall = 1'b0;
    repeat (2) @(posedge clk); #1;
`else
    // Stalled slave: owner keeps the bus indefinitely.
    stall = 1'b1;
    fork
      begin m_cyc[0] = 1'b1; xfer(0, 1'b1, 3'd2, $urandom, lat); m_cyc[0] = 1'b0; end
      begin
        m_cyc[1] = 1'b1;
        repeat (30) @(negedge clk);
        check("held_while_stalled", 32'(gnt), 32'd1);
        stall = 1'b0;
        xfer(1, 1'b0, 3'd2, 32'd0, lat);
        m_cyc[1] = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;
`endif

    // Random traffic, one requester at a time, the other strobing without CYC.
    for (int t = 0; t < 60; t++) begin
      int n, o, nx;
      n = int'($urandom_range(0, 1));
      o = 1 - n;
      nx = int'($urandom_range(1, 3));
      m_cyc[n] = 1'b1;
      for (int k = 0; k < nx; k++) begin
        m_stb[o] = 1'($urandom); m_we[o] = 1'($urandom);
        m_adr[o] = 3'($urandom); m_dat[o] = $urandom;
        xfer(n, 1'($urandom), 3'($urandom), $urandom, lat);
      end
      m_cyc[n] = 1'b0;
      m_stb[o] = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk); #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/wb_bram_arbiter.md
WB_BRAM_ARBITER -- requirements
Module: wb_bram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, cycles of STB without ACK before abort (only used with WB_ARB_TIMEOUT_EN; 1..15).
REQ-002 Port: CLK_I  input  1  system clock; all state on rising edge.
REQ-003 Port: RST_I  input  1  reset, asynchronous, active-high.
REQ-004 Port: Mn_CYC_I  input  1  master n (n=0,1) bus-cycle request.
REQ-005 Port: Mn_STB_I  input  1  master n strobe.
REQ-006 Port: Mn_WE_I  input  1  master n write enable.
REQ-007 Port: Mn_ADR_I  input  3  master n word address.
REQ-008 Port: Mn_DAT_I  input  32  master n write data.
REQ-009 Port: Mn_DAT_O  output  32  read data to master n.
REQ-010 Port: Mn_ACK_O  output  1  acknowledge to master n.
REQ-011 Port: S_STB_O, S_WE_O  output  1 each  strobe/write enable to 8x32 BRAM slave.
REQ-012 Port: S_ADR_O  output  3  slave address.
REQ-013 Port: S_DAT_O  output  32  slave write data.
REQ-014 Port: S_DAT_I  input  32  slave read data.
REQ-015 Port: S_ACK_I  input  1  slave acknowledge (writes same cycle, reads one cycle after STB).
REQ-016 Port: GNT_O  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-017 FSM states IDLE, OWN0, OWN1; state register updates on CLK_I rising edge.
REQ-018 IDLE: only M0_CYC_I -> OWN0; only M1_CYC_I -> OWN1; both -> the master not equal to LAST; neither -> IDLE.
REQ-019 LAST (1-bit) records most recent grant; written on every entry into OWN0 (0) or OWN1 (1).
REQ-020 OWNn: held while Mn_CYC_I=1, no preemption regardless of other master.
REQ-021 OWNn with Mn_CYC_I=0: -> OWNm (m!=n) if Mm_CYC_I=1, else IDLE; no dead cycle on handover.
REQ-022 Slave mux combinational from state: OWNn drives S_STB_O=Mn_STB_I&Mn_CYC_I, S_WE_O=Mn_WE_I, S_ADR_O=Mn_ADR_I, S_DAT_O=Mn_DAT_I; IDLE drives all S_* to 0.
REQ-023 Mn_ACK_O = S_ACK_I & (state==OWNn) & Mn_STB_I; non-owner ACK always 0.
REQ-024 Mn_DAT_O = S_DAT_I for both masters (broadcast; qualified by ACK).
REQ-025 Grant latency: first S_STB_O for a request from IDLE one cycle after CYC first sampled high.
REQ-026 GNT_O = {state==OWN1, state==OWN0}.

Reset
REQ-027 RST_I=1 immediately forces state=IDLE, LAST=1 (M0 wins first tie), timeout counter=0.
REQ-028 During reset all outputs 0: S_*, Mn_ACK_O, GNT_O, Mn_ERR_O; in-flight transfer aborted without ACK.
REQ-029 First grant possible at first rising edge after RST_I deasserts.

Configuration
REQ-030 Macro WB_ARB_TIMEOUT_EN defined: adds ports Mn_ERR_O (output, 1) and a 4-bit counter that increments each cycle in OWNn with S_STB_O=1 and S_ACK_I=0, clears on ACK or state change.
REQ-031 With macro: counter reaching TIMEOUT pulses Mn_ERR_O for one cycle, forces state to IDLE next edge, and LAST is updated so the other master wins any tie.
REQ-032 Without macro: no ERR ports, no counter; owner held indefinitely.

Verification
REQ-033 M0 write ADR=3 DAT=0xDEADBEEF, then read ADR=3 -> M0_ACK_O write cycle and one cycle after read STB, M0_DAT_O=0xDEADBEEF, GNT_O=01.
REQ-034 M0 and M1 raise CYC same cycle after reset -> OWN0 first; M0 drops CYC -> OWN1 next edge, GNT_O 01->10 no idle gap.
REQ-035 Both request continuously, each releasing after one transfer, 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-036 M1 asserts STB while M0 owns -> M1_ACK_O=0, S_ADR_O tracks M0 only, no slave write from M1.
REQ-037 RST_I pulsed mid M1 read -> all outputs 0 same cycle, no ACK, next grant after release goes to M0 on tie.
REQ-038 With WB_ARB_TIMEOUT_EN, TIMEOUT=4, S_ACK_I forced 0 -> M0_ERR_O single pulse after 4 STB cycles, state IDLE, pending M1 granted next.
